// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter sharing one external-memory read port among NUM_REQ burst requesters.
// Optional WAIT-state timeout abort is compiled in when EXT_MEM_ARB_TIMEOUT_EN is defined.
module ext_mem_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 24,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [31:0]               req_rdata,
  output logic [NUM_REQ-1:0]        req_rvalid,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      ext_mem_rd,
  output logic [ADDR_W-1:0]         ext_mem_addr,
  input  logic [31:0]               ext_mem_rdata,
  input  logic                      ext_mem_rvalid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("ext_mem_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     own_q, own_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rd_q, rd_d;
  logic                 found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;

`ifdef EXT_MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 err_q, err_d;
`endif

  // First requester at or after the round-robin pointer, scanning circularly.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no latch is inferred.
    state_d  = state_q;
    rr_d     = rr_q;
    own_d    = own_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    done_d   = '0;
    rd_d     = 1'b0;
`ifdef EXT_MEM_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          own_d   = pick_idx;
          addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          len_d   = req_len[int'(pick_idx)*LEN_W +: LEN_W];
          cnt_d   = '0;
          grant_d = NUM_REQ'(1) << pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_d    = 1'b1;
`ifdef EXT_MEM_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (ext_mem_rvalid) begin
          rdata_d  = ext_mem_rdata;
          rvalid_d = grant_q;
          addr_d   = addr_q + 1'b1;
          if (cnt_q == len_q) begin
            done_d  = grant_q;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ISSUE;
          end
        end
`ifdef EXT_MEM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      DONE: begin
        grant_d = '0;
        rr_d    = (own_q == IDX_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      own_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
`ifdef EXT_MEM_ARB_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
      state_q  <= state_d;
      rr_q     <= rr_d;
      own_q    <= own_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
`ifdef EXT_MEM_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign req_grant    = grant_q;
  assign req_rvalid   = rvalid_q;
  assign req_done     = done_q;
  assign req_rdata    = rdata_q;
  assign busy         = (state_q != IDLE);
  assign ext_mem_rd   = rd_q;
  assign ext_mem_addr = addr_q;
`ifdef EXT_MEM_ARB_TIMEOUT_EN
  assign err_timeout  = err_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Randomized self-checking bench for ext_mem_arbiter: a queue-based round-robin model predicts
// grant order, read addresses and routed data; a latency-programmable memory answers reads.
module tb_ext_mem_arbiter;
  localparam int N   = 3;
  localparam int AW  = 24;
  localparam int LW  = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_grant, req_rvalid, req_done;
  logic [31:0]     req_rdata;
  logic            busy, err_timeout, ext_mem_rd;
  logic [AW-1:0]   ext_mem_addr;
  logic [31:0]     ext_mem_rdata;
  logic            ext_mem_rvalid;

  logic            mem_rvalid = 1'b0;
  logic [31:0]     mem_rdata  = '0;
  logic            stray_v    = 1'b0;
  bit              mem_en     = 1'b0;
  int              mem_lat    = 2;

  assign ext_mem_rvalid = mem_rvalid | stray_v;
  assign ext_mem_rdata  = stray_v ? 32'hDEAD_BEEF : mem_rdata;

  ext_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_grant(req_grant), .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_done(req_done),
    .busy(busy), .err_timeout(err_timeout), .ext_mem_rd(ext_mem_rd), .ext_mem_addr(ext_mem_addr),
    .ext_mem_rdata(ext_mem_rdata), .ext_mem_rvalid(ext_mem_rvalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [AW-1:0] addr; logic [LW-1:0] len;} job_t;
  typedef struct {int own; logic [AW-1:0] addr; logic [LW-1:0] len;} exp_t;
  typedef struct {int own; logic [31:0] d;} rv_t;
  typedef struct {logic [AW-1:0] addr; int due;} pend_t;

  job_t  jobs [N][$];
  int    rr_model = 0;

  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return {~a[7:0], a};
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Memory: answers each read pulse exactly mem_lat cycles later.
  pend_t pend[$];
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_fn(pend[0].addr);
      void'(pend.pop_front());
    end
    if (mem_en && ext_mem_rd) pend.push_back('{addr: ext_mem_addr, due: cyc + mem_lat});
  end

  // Passive monitor: logs events; the test tasks do the comparing.
  int            grant_log[$], grant_cyc_log[$], rd_cyc_log[$], done_log[$];
  logic [AW-1:0] rd_log[$];
  rv_t           rv_log[$];
  int            err_cyc = 0, err_cnt = 0, onehot_viol = 0, done_viol = 0;
  logic [N-1:0]  mon_prev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(req_grant) > 1 || $countones(req_rvalid) > 1 || $countones(req_done) > 1)
        onehot_viol++;
      if (req_grant != '0 && mon_prev == '0) begin
        grant_log.push_back(oh_idx(req_grant));
        grant_cyc_log.push_back(cyc);
      end
      if (ext_mem_rd) begin
        rd_log.push_back(ext_mem_addr);
        rd_cyc_log.push_back(cyc);
      end
      if (req_rvalid != '0) rv_log.push_back('{own: oh_idx(req_rvalid), d: req_rdata});
      if (req_done != '0) begin
        done_log.push_back(oh_idx(req_done));
        if (!err_timeout && req_rvalid !== req_done) done_viol++;
      end
      if (err_timeout) begin
        err_cyc = cyc;
        err_cnt++;
      end
    end
    mon_prev = rst ? '0 : req_grant;
  end

  int last_req_cyc = 0;
  int last_gb = 0, last_rb = 0;

  // Presents the queued jobs, predicts the round-robin service order, and checks all traffic.
  task automatic run_jobs(input string tag);
    exp_t exp[$];
    job_t work[N][$];
    int p, pick, total, gb, rb, vb, db, budget, r, v;
    logic [N-1:0] prev;
    logic [AW-1:0] ea;
    for (int i = 0; i < N; i++) work[i] = jobs[i];
    p = rr_model;
    forever begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && work[(p + k) % N].size() > 0) pick = (p + k) % N;
      if (pick < 0) break;
      exp.push_back('{own: pick, addr: work[pick][0].addr, len: work[pick][0].len});
      void'(work[pick].pop_front());
      p = (pick + 1) % N;
    end
    rr_model = p;
    total = exp.size();
    gb = grant_log.size(); rb = rd_log.size(); vb = rv_log.size(); db = done_log.size();
    last_gb = gb; last_rb = rb;
    @(negedge clk);
    last_req_cyc = cyc;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (jobs[i].size() > 0);
      if (jobs[i].size() > 0) begin
        req_addr[i*AW +: AW] = jobs[i][0].addr;
        req_len[i*LW +: LW]  = jobs[i][0].len;
      end
    end
    prev = '0; budget = 0;
    while (done_log.size() - db < total && budget < 3000) begin
      @(negedge clk); budget++;
      for (int i = 0; i < N; i++) if (req_grant[i] && !prev[i]) begin
        void'(jobs[i].pop_front());
        if (jobs[i].size() == 0) req_valid[i] = 1'b0;
        else begin
          req_addr[i*AW +: AW] = jobs[i][0].addr;
          req_len[i*LW +: LW]  = jobs[i][0].len;
        end
      end
      prev = req_grant;
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (budget >= 3000) begin
      errors++; $display("FAIL %s_timeout: done %0d of %0d bursts", tag, done_log.size() - db, total);
    end
    r = rb; v = vb;
    for (int b = 0; b < total; b++) begin
      checks++;
      if (gb + b >= grant_log.size() || grant_log[gb + b] !== exp[b].own) begin
        errors++; $display("FAIL %s_grant[%0d]: got %0d want %0d", tag, b,
          (gb + b < grant_log.size()) ? grant_log[gb + b] : -1, exp[b].own);
      end
      checks++;
      if (db + b >= done_log.size() || done_log[db + b] !== exp[b].own) begin
        errors++; $display("FAIL %s_done[%0d]: got %0d want %0d", tag, b,
          (db + b < done_log.size()) ? done_log[db + b] : -1, exp[b].own);
      end
      for (int w = 0; w <= int'(exp[b].len); w++) begin
        ea = exp[b].addr + AW'(w);
        checks++;
        if (r >= rd_log.size() || rd_log[r] !== ea) begin
          errors++; $display("FAIL %s_rdaddr[%0d.%0d]: got %h want %h", tag, b, w,
            (r < rd_log.size()) ? rd_log[r] : 'x, ea);
        end
        checks++;
        if (v >= rv_log.size() || rv_log[v].own !== exp[b].own || rv_log[v].d !== mem_fn(ea)) begin
          errors++; $display("FAIL %s_rdata[%0d.%0d]: got own %0d data %h want own %0d data %h", tag, b, w,
            (v < rv_log.size()) ? rv_log[v].own : -1, (v < rv_log.size()) ? rv_log[v].d : 'x,
            exp[b].own, mem_fn(ea));
        end
        r++; v++;
      end
    end
    checks++;
    if (rd_log.size() !== r || rv_log.size() !== v) begin
      errors++; $display("FAIL %s_extra: got %0d reads %0d rvalids want %0d %0d", tag,
        rd_log.size() - rb, rv_log.size() - vb, r - rb, v - vb);
    end
    checks++;
    if (onehot_viol !== 0 || done_viol !== 0) begin
      errors++; $display("FAIL %s_onehot: got %0d onehot and %0d done/rvalid violations want 0", tag,
        onehot_viol, done_viol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_grant, req_rvalid, req_done, err_timeout, ext_mem_rd, ext_mem_addr, req_rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got grant %b rvalid %b done %b err %b rd %b addr %h data %h want all 0",
        req_grant, req_rvalid, req_done, err_timeout, ext_mem_rd, ext_mem_addr, req_rdata);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; rr_model = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    mem_en = 1'b1; mem_lat = 1;
    jobs[0].push_back('{addr: 24'h00A000, len: 4'd0});
    jobs[0].push_back('{addr: 24'h00A100, len: 4'd0});
    jobs[1].push_back('{addr: 24'h00B000, len: 4'd0});
    jobs[2].push_back('{addr: 24'h00C000, len: 4'd0});
    run_jobs("contention");
  endtask

  task automatic test_single();
    mem_lat = 2;
    jobs[0].push_back('{addr: 24'h001000, len: 4'd3});
    run_jobs("single");
    checks++;
    if (grant_cyc_log[last_gb] !== last_req_cyc + 1) begin
      errors++; $display("FAIL single_grant_lat: got %0d want %0d", grant_cyc_log[last_gb] - last_req_cyc, 1);
    end
    checks++;
    if (rd_cyc_log[last_rb] !== last_req_cyc + 2) begin
      errors++; $display("FAIL single_rd_lat: got %0d want %0d", rd_cyc_log[last_rb] - last_req_cyc, 2);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 3;
    jobs[2].push_back('{addr: 24'hFFFFFE, len: 4'd3});
    run_jobs("wrap");
  endtask

  task automatic test_stray();
    int vb, db, budget;
    vb = rv_log.size();
    @(negedge clk); stray_v = 1'b1;
    @(negedge clk); stray_v = 1'b0;
    @(negedge clk);
    checks++;
    if (rv_log.size() !== vb || busy !== 1'b0) begin
      errors++; $display("FAIL stray_idle: got %0d rvalids busy %b want 0 rvalids busy 0", rv_log.size() - vb, busy);
    end
    mem_lat = 3; db = done_log.size();
    req_valid[1] = 1'b1; req_addr[1*AW +: AW] = 24'h002000; req_len[1*LW +: LW] = 4'd2;
    budget = 0;
    while (req_grant[1] !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    stray_v = 1'b1;
    @(negedge clk); stray_v = 1'b0; req_valid = '0;
    budget = 0;
    while (done_log.size() == db && budget < 200) begin @(negedge clk); budget++; end
    rr_model = 2;
    repeat (2) @(negedge clk);
    checks++;
    if (rv_log.size() - vb !== 3) begin
      errors++; $display("FAIL stray_count: got %0d rvalids want 3", rv_log.size() - vb);
    end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (vb + w >= rv_log.size() || rv_log[vb + w].d !== mem_fn(24'h002000 + AW'(w))) begin
        errors++; $display("FAIL stray_data[%0d]: got %h want %h", w,
          (vb + w < rv_log.size()) ? rv_log[vb + w].d : 'x, mem_fn(24'h002000 + AW'(w)));
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      mem_lat = $urandom_range(1, 4);
      for (int i = 0; i < N; i++) begin
        int n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) begin
          logic [AW-1:0] a = ($urandom_range(0, 3) == 0) ? 24'hFFFFF0 + AW'($urandom_range(0, 15))
                                                          : AW'($urandom);
          jobs[i].push_back('{addr: a, len: LW'($urandom_range(0, 15))});
        end
      end
      run_jobs($sformatf("random%0d", round));
    end
  endtask

  task automatic test_reset_mid_burst();
    int rb, vb, budget;
    mem_lat = 6; rb = rd_log.size();
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0 +: AW] = 24'h005000; req_len[0 +: LW] = 4'd7;
    budget = 0;
    while (rd_log.size() - rb < 2 && budget < 100) begin @(negedge clk); budget++; end
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    #1;
    checks++;
    if ({req_grant, req_rvalid, req_done, busy, ext_mem_rd, ext_mem_addr, req_rdata} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got grant %b rvalid %b done %b busy %b rd %b addr %h want all 0",
        req_grant, req_rvalid, req_done, busy, ext_mem_rd, ext_mem_addr);
    end
    @(negedge clk); rst = 1'b0; rr_model = 0;
    vb = rv_log.size();
    repeat (12) @(negedge clk);
    checks++;
    if (rv_log.size() !== vb || busy !== 1'b0 || pend.size() !== 0) begin
      errors++; $display("FAIL midreset_late_rvalid: got %0d rvalids busy %b pending %0d want 0 0 0",
        rv_log.size() - vb, busy, pend.size());
    end
    mem_lat = 2;
    jobs[1].push_back('{addr: 24'h006000, len: 4'd1});
    run_jobs("after_reset");
  endtask

`ifdef EXT_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int vb, ec, db, budget;
    mem_en = 1'b0; vb = rv_log.size(); ec = err_cnt; db = done_log.size();
    @(negedge clk);
    req_valid = 3'b011;
    req_addr[0 +: AW] = 24'h003000; req_len[0 +: LW] = 4'd1;
    req_addr[AW +: AW] = 24'h004000; req_len[LW +: LW] = 4'd0;
    budget = 0;
    while (err_cnt == ec && budget < 200) begin
      @(negedge clk); budget++;
      if (req_grant[0]) req_valid[0] = 1'b0;
    end
    checks++;
    if (err_cyc - rd_cyc_log[$] !== TMO) begin
      errors++; $display("FAIL timeout_latency: got %0d want %0d", err_cyc - rd_cyc_log[$], TMO);
    end
    checks++;
    if (done_log.size() - db !== 1 || done_log[$] !== 0 || rv_log.size() !== vb) begin
      errors++; $display("FAIL timeout_done: got %0d dones owner %0d rvalids %0d want 1 0 0",
        done_log.size() - db, done_log[$], rv_log.size() - vb);
    end
    budget = 0;
    while (req_grant !== 3'b010 && budget < 20) begin @(negedge clk); budget++; end
    mem_en = 1'b1; mem_lat = 2; req_valid = '0;
    budget = 0;
    while (done_log.size() - db < 2 && budget < 100) begin @(negedge clk); budget++; end
    rr_model = 2;
    checks++;
    if (grant_log[$] !== 1 || rv_log.size() - vb !== 1 || rv_log[$].d !== mem_fn(24'h004000)) begin
      errors++; $display("FAIL timeout_next: got owner %0d rvalids %0d want owner 1 rvalids 1",
        grant_log[$], rv_log.size() - vb);
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_stray();
    test_random();
    test_reset_mid_burst();
`ifdef EXT_MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
